// File: rtl/ha_array_accumulator.sv
// ============================================================================
// ha_array_accumulator
// ----------------------------------------------------------------------------
// Back-end reducer for the four half-adder arrays produced by the unsigned
// 8x8 approximate multiplier front-ends. One set of arrays is captured per
// input handshake. The four weighted rows are then summed over several
// cycles into an OUT_W-bit product, which is offered on a valid/ready output.
//
// Row value:  A_k = t_k + (b_k << 2)
// Product:    P   = sum_k A_k << 2k
//
// Optional feature macro: HA_ACC_DUAL_EN
//   defined   -> two rows are added per ACC cycle (ACC lasts 2 cycles)
//   undefined -> one row is added per ACC cycle (ACC lasts 4 cycles)
//
// Ports
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready is high only in IDLE
//   ha_array_k_b (k=0-3) 7-bit carry row k
//   ha_array_k_t (k=0-3) 9-bit sum row k
//   out_valid/out_ready  output handshake; out_valid is high only in DONE
//   product              reduced product, low OUT_W bits of P
//   out_ovf              sticky flag: the reduction carried past bit OUT_W-1
//   op_count             completed output handshakes, wraps mod 2^CNT_W
// ============================================================================
module ha_array_accumulator #(
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [6:0]       ha_array_1_b,
    input  logic [6:0]       ha_array_2_b,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [8:0]       ha_array_1_t,
    input  logic [8:0]       ha_array_2_t,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             out_ovf,
    output logic [CNT_W-1:0] op_count
);

    // A product narrower than 16 bits cannot hold the weighted row sum.
    if (OUT_W < 16) begin : gBadWidth
        $error("ha_array_accumulator: OUT_W must be at least 16");
    end

    // Two extra bits hold the carry-out of one step. In dual mode, two
    // rows plus the running sum can carry by up to 2.
    localparam int SUM_W = OUT_W + 2;

`ifdef HA_ACC_DUAL_EN
    localparam logic [1:0] IDX_STEP = 2'd2;
    localparam logic [1:0] IDX_LAST = 2'd2;
`else
    localparam logic [1:0] IDX_STEP = 2'd1;
    localparam logic [1:0] IDX_LAST = 2'd3;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [6:0]         rowB_q [4];
    logic [8:0]         rowT_q [4];
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   opCount_q, opCount_d;
    logic [SUM_W-1:0]   stepSum;
    logic               accept;

    // Row k weighted into product position: (t + 4b) << 2k.
    function automatic logic [SUM_W-1:0] weightedRow(input logic [8:0] t,
                                                     input logic [6:0] b,
                                                     input logic [1:0] k);
        logic [SUM_W-1:0] rowVal;
        rowVal = SUM_W'(t) + (SUM_W'(b) << 2);
        return rowVal << {k, 1'b0};
    endfunction

    assign accept = (state_q == IDLE) && in_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, step through the rows in ACC,
    // and wait for the output handshake in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)           state_d = ACC;
            ACC:     if (idx_q == IDX_LAST)  state_d = DONE;
            DONE:    if (out_ready)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Handshake flags are pure state decodes, so no input reaches them.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state. The carry out of bit OUT_W-1 is folded into the
    // sticky overflow flag, and only the low OUT_W bits are kept.
    always_comb begin
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        idx_d     = idx_q;
        opCount_d = opCount_q;
        stepSum   = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    idx_d = 2'd0;
                end
            end
            ACC: begin
                stepSum = {2'b00, acc_q}
                        + weightedRow(rowT_q[idx_q], rowB_q[idx_q], idx_q);
`ifdef HA_ACC_DUAL_EN
                stepSum = stepSum
                        + weightedRow(rowT_q[idx_q | 2'd1], rowB_q[idx_q | 2'd1],
                                      idx_q | 2'd1);
`endif
                acc_d = stepSum[OUT_W-1:0];
                ovf_d = ovf_q | (|stepSum[SUM_W-1:OUT_W]);
                idx_d = idx_q + IDX_STEP;
            end
            DONE: begin
                if (out_ready) begin
                    opCount_d = opCount_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            idx_q     <= 2'd0;
            opCount_q <= '0;
        end else begin
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            idx_q     <= idx_d;
            opCount_q <= opCount_d;
        end
    end

    // Input arrays are captured only on the accept edge. Later changes on
    // the input pins have no effect on the running operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                rowB_q[k] <= '0;
                rowT_q[k] <= '0;
            end
        end else if (accept) begin
            rowB_q[0] <= ha_array_0_b;
            rowB_q[1] <= ha_array_1_b;
            rowB_q[2] <= ha_array_2_b;
            rowB_q[3] <= ha_array_3_b;
            rowT_q[0] <= ha_array_0_t;
            rowT_q[1] <= ha_array_1_t;
            rowT_q[2] <= ha_array_2_t;
            rowT_q[3] <= ha_array_3_t;
        end
    end

    assign product  = acc_q;
    assign out_ovf  = ovf_q;
    assign op_count = opCount_q;

endmodule
